uart_tx: RTL and testbench

Serial transmitter for the UART block: accepts one parallel byte per frame over a valid/busy handshake and shifts it out as start bit, 8 data bits, optional parity bit and stop bit on a single line. It is the counterpart of the UART receive path and is clocked at the bit rate, one `clk` cycle per serial bit. Any baud-rate division happens upstream of `clk`.

---
 rtl/uart_tx_pkg.sv | 21 ++
 rtl/uart_tx_serializer.sv | 43 ++++
 rtl/uart_tx.sv | 105 ++++++++++
 tb/tb_uart_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmit path.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int   IDX_W     = 3;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// MSB-first shift register feeding the transmit FSM one payload bit per cycle.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] par_data,
  output logic                  ser_data,
  output logic                  ser_done
);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_started;

  // The first shift happens on the START edge so the MSB always holds the bit
  // the FSM registers next; r_started keeps that shift out of the DATA index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift   <= '0;
      r_idx     <= '0;
      r_started <= 1'b0;
    end else if (load) begin
      r_shift   <= par_data;
      r_idx     <= '0;
      r_started <= 1'b0;
    end else if (shift_en) begin
      r_shift   <= {r_shift[DATA_WIDTH-2:0], 1'b0};
      r_started <= 1'b1;
      if (r_started) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign ser_data = r_shift[DATA_WIDTH-1];
  assign ser_done = r_started && (r_idx == IDX_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, MSB-first payload, optional parity, stop bit,
// one bit per clk cycle with registered TX_OUT and Busy.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  state_t r_state;
  logic   r_tx;
  logic   r_busy;
  logic   r_parEn;
  logic   r_parBit;

  logic   w_accept;
  logic   w_shiftEn;
  logic   w_serData;
  logic   w_serDone;

  assign w_accept  = (r_state == IDLE) && Data_Valid;
  assign w_shiftEn = (r_state == START) || (r_state == DATA);

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_accept),
    .shift_en (w_shiftEn),
    .par_data (P_DATA),
    .ser_data (w_serData),
    .ser_done (w_serDone)
  );

  // Parity is resolved at accept time because the shift register consumes the
  // byte; the value equals the XOR of the latched byte and latched PAR_TYP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_tx     <= LINE_IDLE;
      r_busy   <= 1'b0;
      r_parEn  <= 1'b0;
      r_parBit <= PAR_EVEN;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (Data_Valid) begin
            r_state  <= START;
            r_tx     <= START_BIT;
            r_busy   <= 1'b1;
            r_parEn  <= PAR_EN;
            r_parBit <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
          end else begin
            r_tx   <= LINE_IDLE;
            r_busy <= 1'b0;
          end
        end
        START: begin
          r_state <= DATA;
          r_tx    <= w_serData;
        end
        DATA: begin
          if (w_serDone) begin
            if (r_parEn) begin
              r_state <= PARITY;
              r_tx    <= r_parBit;
            end else begin
              r_state <= STOP;
              r_tx    <= STOP_BIT;
            end
          end else begin
            r_tx <= w_serData;
          end
        end
        PARITY: begin
          r_state <= STOP;
          r_tx    <= STOP_BIT;
        end
        STOP: begin
          r_state <= IDLE;
          r_tx    <= LINE_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= LINE_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = r_tx;
  assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx; frames are hand-written bit strings
// listed in line order (start bit leftmost).
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int nTests = 0;
  int nFail  = 0;

  uart_tx #(
    .DATA_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge in IDLE; returns at the falling edge of the START cycle.
  task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic pt);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    Data_Valid = 1'b1;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nTests++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL reset cycle %0d: TX_OUT=%b Busy=%b expected 1/0", i, TX_OUT, Busy);
      end
    end
    Data_Valid = 1'b0;
    rst        = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nTests++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL post_reset cycle %0d: TX_OUT=%b Busy=%b expected 1/0", i, TX_OUT, Busy);
      end
    end
  endtask

  task automatic test_no_parity();
    logic [9:0] exp;
    exp = 10'b0_10100101_1;
    applyStimulus(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      nTests++;
      if (TX_OUT !== exp[9-i] || Busy !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL no_parity bit %0d: TX_OUT=%b Busy=%b expected %b/1", i, TX_OUT, Busy, exp[9-i]);
      end
      @(negedge clk);
    end
    nTests++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL no_parity end: TX_OUT=%b Busy=%b expected 1/0", TX_OUT, Busy);
    end
  endtask

  task automatic test_parity();
    logic [7:0]  vData [4];
    logic        vTyp  [4];
    logic [10:0] vExp  [4];
    vData[0] = 8'hA5; vTyp[0] = 1'b0; vExp[0] = 11'b0_10100101_0_1;
    vData[1] = 8'hA5; vTyp[1] = 1'b1; vExp[1] = 11'b0_10100101_1_1;
    vData[2] = 8'hFF; vTyp[2] = 1'b1; vExp[2] = 11'b0_11111111_1_1;
    vData[3] = 8'h00; vTyp[3] = 1'b0; vExp[3] = 11'b0_00000000_0_1;
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vData[v], 1'b1, vTyp[v]);
      for (int i = 0; i < 11; i++) begin
        nTests++;
        if (TX_OUT !== vExp[v][10-i] || Busy !== 1'b1) begin
          nFail++;
          $display("[TB] FAIL parity vec %0d bit %0d: TX_OUT=%b Busy=%b expected %b/1",
                   v, i, TX_OUT, Busy, vExp[v][10-i]);
        end
        @(negedge clk);
      end
      nTests++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL parity vec %0d end: TX_OUT=%b Busy=%b expected 1/0", v, TX_OUT, Busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp1;
    logic [9:0] exp2;
    exp1 = 10'b0_00111100_1;
    exp2 = 10'b0_11000011_1;
    P_DATA     = 8'h3C;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      nTests++;
      if (TX_OUT !== exp1[9-i] || Busy !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL b2b first bit %0d: TX_OUT=%b Busy=%b expected %b/1", i, TX_OUT, Busy, exp1[9-i]);
      end
      if (i == 3) P_DATA = 8'hC3;
      @(negedge clk);
    end
    nTests++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL b2b gap: TX_OUT=%b Busy=%b expected 1/0", TX_OUT, Busy);
    end
    @(negedge clk);
    Data_Valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      nTests++;
      if (TX_OUT !== exp2[9-i] || Busy !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL b2b second bit %0d: TX_OUT=%b Busy=%b expected %b/1", i, TX_OUT, Busy, exp2[9-i]);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      nTests++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL b2b tail %0d: TX_OUT=%b Busy=%b expected 1/0", i, TX_OUT, Busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] exp;
    exp = 10'b0_00000000_1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      nTests++;
      if (TX_OUT !== exp[9-i] || Busy !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL abort pre bit %0d: TX_OUT=%b Busy=%b expected %b/1", i, TX_OUT, Busy, exp[9-i]);
      end
      if (i == 4) rst = 1'b0;
      @(negedge clk);
    end
    nTests++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL abort reset: TX_OUT=%b Busy=%b expected 1/0", TX_OUT, Busy);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nTests++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL abort no_resume %0d: TX_OUT=%b Busy=%b expected 1/0", i, TX_OUT, Busy);
      end
    end
    exp = 10'b0_10000001_1;
    applyStimulus(8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      nTests++;
      if (TX_OUT !== exp[9-i] || Busy !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL abort resend bit %0d: TX_OUT=%b Busy=%b expected %b/1", i, TX_OUT, Busy, exp[9-i]);
      end
      @(negedge clk);
    end
    nTests++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL abort resend end: TX_OUT=%b Busy=%b expected 1/0", TX_OUT, Busy);
    end
  endtask

  task automatic test_ignored_request();
    logic [10:0] exp;
    exp = 11'b0_10010110_1_1;
    applyStimulus(8'h96, 1'b1, 1'b1);
    for (int i = 0; i < 11; i++) begin
      nTests++;
      if (TX_OUT !== exp[10-i] || Busy !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL ignored bit %0d: TX_OUT=%b Busy=%b expected %b/1", i, TX_OUT, Busy, exp[10-i]);
      end
      if (i == 5) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
      end
      if (i == 6) Data_Valid = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      nTests++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL ignored tail %0d: TX_OUT=%b Busy=%b expected 1/0", i, TX_OUT, Busy);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_ignored_request();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
